// File: rtl/ula_display_driver_if.sv
// Bundle between the ALU result source and the display driver.
// The master drives the result; the slave owns busy and the display lines.
interface ula_display_driver_if;
    localparam int unsigned RES_W = 6;
    localparam int unsigned AN_W  = 3;
    localparam int unsigned SEG_W = 7;

    logic [RES_W-1:0] result;
    logic             led_neg;
    logic             led_overflow;
    logic             busy;
    logic [AN_W-1:0]  an;
    logic [SEG_W-1:0] seg;

    modport master (
        output result, led_neg, led_overflow,
        input  busy, an, seg
    );

    modport slave (
        input  result, led_neg, led_overflow,
        output busy, an, seg
    );
endinterface

// File: rtl/ula_display_driver.sv
// Sistema_ULA display stage: change-triggered sequential double-dabble conversion
// feeding a multiplexed, active-low 3-digit 7-segment display.
module ula_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input logic                 clk,
    input logic                 reset,
    ula_display_driver_if.slave bus
);
    localparam int unsigned RES_W      = 6;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned AN_W       = 3;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned ITER_W     = 3;
    localparam int unsigned DD_W       = 2 * BCD_W + RES_W;
    localparam int unsigned CNT_W      = $clog2(REFRESH_DIV);
    localparam int unsigned CONV_STEPS = RES_W;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_R     = 7'b0101111;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LATCH
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                capture;
    logic                latch;

    logic [RES_W-1:0]    snap_result;
    logic                snap_neg;
    logic                snap_ovf;
    logic                snap_valid;
    logic                changed;

    logic [ITER_W-1:0]   iter;
    logic [RES_W-1:0]    mag;
    logic [RES_W-1:0]    mag_in;
    logic [BCD_W-1:0]    bcd_t;
    logic [BCD_W-1:0]    bcd_u;
    logic [BCD_W-1:0]    t_adj;
    logic [BCD_W-1:0]    u_adj;
    logic [DD_W-1:0]     dd_next;

    logic [SEG_W-1:0]    dig_s;
    logic [SEG_W-1:0]    dig_t;
    logic [SEG_W-1:0]    dig_u;
    logic [SEG_W-1:0]    sign_n;
    logic [SEG_W-1:0]    tens_n;
    logic [SEG_W-1:0]    units_n;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [SEG_W-1:0]    sel_seg;
    logic                busy_q;
    logic [AN_W-1:0]     an_q;
    logic [SEG_W-1:0]    seg_q;

    function automatic logic [SEG_W-1:0] digit_seg(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    digit_seg = 7'b1000000;
            4'd1:    digit_seg = 7'b1111001;
            4'd2:    digit_seg = 7'b0100100;
            4'd3:    digit_seg = 7'b0110000;
            4'd4:    digit_seg = 7'b0011001;
            4'd5:    digit_seg = 7'b0010010;
            4'd6:    digit_seg = 7'b0000010;
            4'd7:    digit_seg = 7'b1111000;
            4'd8:    digit_seg = 7'b0000000;
            4'd9:    digit_seg = 7'b0010000;
            default: digit_seg = SEG_BLANK;
        endcase
    endfunction

    // Snapshot comparison makes conversions happen only on a real input change
    assign changed = !snap_valid
                   || ({bus.result, bus.led_neg, bus.led_overflow}
                       != {snap_result, snap_neg, snap_ovf});
    assign mag_in  = bus.led_neg ? RES_W'(~bus.result + RES_W'(1)) : bus.result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        latch      = 1'b0;
        unique case (state)
            IDLE: begin
                if (changed) begin
                    capture    = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (iter == ITER_W'(CONV_STEPS - 1)) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                latch      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble iteration: add-3 correction then shift
    always_comb begin
        t_adj = bcd_t;
        u_adj = bcd_u;
        if (bcd_t >= BCD_W'(5)) t_adj = bcd_t + BCD_W'(3);
        if (bcd_u >= BCD_W'(5)) u_adj = bcd_u + BCD_W'(3);
        dd_next = {t_adj, u_adj, mag} << 1;
    end

    // Digit contents to hold next; only LATCH changes them
    always_comb begin
        sign_n  = dig_s;
        tens_n  = dig_t;
        units_n = dig_u;
        if (latch) begin
            if (snap_ovf) begin
                sign_n  = SEG_E;
                tens_n  = SEG_R;
                units_n = SEG_R;
            end else begin
                sign_n  = snap_neg ? SEG_DASH : SEG_BLANK;
                tens_n  = (bcd_t == BCD_W'(0)) ? SEG_BLANK : digit_seg(bcd_t);
                units_n = digit_seg(bcd_u);
            end
        end
    end

    always_comb begin
        sel_seg = SEG_BLANK;
        case (idx)
            IDX_W'(0): sel_seg = units_n;
            IDX_W'(1): sel_seg = tens_n;
            IDX_W'(2): sel_seg = sign_n;
            default:   sel_seg = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_result <= '0;
            snap_neg    <= 1'b0;
            snap_ovf    <= 1'b0;
            snap_valid  <= 1'b0;
            busy_q      <= 1'b0;
            iter        <= '0;
            mag         <= '0;
            bcd_t       <= '0;
            bcd_u       <= '0;
            dig_s       <= SEG_BLANK;
            dig_t       <= SEG_BLANK;
            dig_u       <= SEG_BLANK;
        end else begin
            if (capture) begin
                snap_result <= bus.result;
                snap_neg    <= bus.led_neg;
                snap_ovf    <= bus.led_overflow;
                snap_valid  <= 1'b1;
                busy_q      <= 1'b1;
                iter        <= '0;
                mag         <= mag_in;
                bcd_t       <= '0;
                bcd_u       <= '0;
            end else if (state == CONV) begin
                {bcd_t, bcd_u, mag} <= dd_next;
                iter                <= iter + ITER_W'(1);
            end
            if (latch) busy_q <= 1'b0;
            dig_s <= sign_n;
            dig_t <= tens_n;
            dig_u <= units_n;
        end
    end

    // Refresh scan: an and seg leave the same register stage together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            idx   <= '0;
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(2)) ? IDX_W'(0) : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            an_q  <= ~(AN_W'(1) << idx);
            seg_q <= sel_seg;
        end
    end

    assign bus.busy = busy_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
endmodule

// File: tb/tb_ula_display_driver.sv
// Bench for ula_display_driver: vector table, random vectors against a decimal model,
// and hand-written sequences for reset and mid-conversion input changes.
module tb_ula_display_driver;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DA = 7'b0111111;
    localparam logic [6:0] EE = 7'b0000110;
    localparam logic [6:0] RR = 7'b0101111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;

    typedef struct {
        logic [5:0] result;
        logic       neg;
        logic       ovf;
        logic [6:0] s;
        logic [6:0] t;
        logic [6:0] u;
    } vec_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    logic [6:0] enc [10];
    vec_t vecs [9];

    ula_display_driver_if bus ();

    ula_display_driver #(.REFRESH_DIV(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic [5:0] r, input logic n, input logic o);
        bus.result       = r;
        bus.led_neg      = n;
        bus.led_overflow = o;
    endtask

    // Decimal reference: digits straight from integer arithmetic
    task automatic model(input logic [5:0] r, input logic n, input logic o,
                         output logic [6:0] s, output logic [6:0] t, output logic [6:0] u);
        int mag;
        if (o) begin
            s = EE; t = RR; u = RR;
        end else begin
            mag = n ? (64 - int'(r)) % 64 : int'(r);
            s = n ? DA : BL;
            t = (mag / 10 == 0) ? BL : enc[mag / 10];
            u = enc[mag % 10];
        end
    endtask

    // Called right after a negedge with new inputs already driven; next posedge is E0
    task automatic run_conv(input string name, input bit check_blank);
        bit busy_ok;
        bit blank_ok;
        busy_ok  = 1'b1;
        blank_ok = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.seg !== BL) blank_ok = 1'b0;
        end
        chk({name, "_busy_E0_E6"}, int'(busy_ok), 1);
        if (check_blank) chk({name, "_blank_during_conv"}, int'(blank_ok), 1);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_busy_drop_E7"}, int'(bus.busy), 0);
    endtask

    task automatic read_display(output logic [6:0] s, output logic [6:0] t,
                                output logic [6:0] u, output bit an_ok, output bit idle_ok);
        bit seen_s, seen_t, seen_u;
        s = BL; t = BL; u = BL;
        an_ok = 1'b1; idle_ok = 1'b1;
        seen_s = 1'b0; seen_t = 1'b0; seen_u = 1'b0;
        for (int k = 0; k < 16; k++) begin
            case (bus.an)
                3'b110:  begin u = bus.seg; seen_u = 1'b1; end
                3'b101:  begin t = bus.seg; seen_t = 1'b1; end
                3'b011:  begin s = bus.seg; seen_s = 1'b1; end
                default: an_ok = 1'b0;
            endcase
            if (bus.busy !== 1'b0) idle_ok = 1'b0;
            @(negedge clk);
        end
        if (!(seen_s && seen_t && seen_u)) an_ok = 1'b0;
    endtask

    task automatic check_display(input string name, input logic [6:0] es,
                                 input logic [6:0] et, input logic [6:0] eu);
        logic [6:0] s, t, u;
        bit an_ok, idle_ok;
        read_display(s, t, u, an_ok, idle_ok);
        chk({name, "_sign"}, int'(s), int'(es));
        chk({name, "_tens"}, int'(t), int'(et));
        chk({name, "_units"}, int'(u), int'(eu));
        chk({name, "_an_onehot"}, int'(an_ok), 1);
        chk({name, "_no_recapture"}, int'(idle_ok), 1);
    endtask

    task automatic check_rotation();
        logic [2:0] prev;
        logic [2:0] pat [3];
        bit found;
        bit ok;
        pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;
        found = 1'b0;
        ok    = 1'b1;
        prev  = bus.an;
        for (int k = 0; k < 16 && !found; k++) begin
            @(negedge clk);
            if (bus.an == 3'b110 && prev == 3'b011) found = 1'b1;
            else prev = bus.an;
        end
        chk("rotation_found", int'(found), 1);
        if (found) begin
            for (int k = 0; k < 12; k++) begin
                if (bus.an !== pat[k / 4]) ok = 1'b0;
                @(negedge clk);
            end
            chk("rotation_sequence", int'(ok), 1);
        end
    endtask

    initial begin
        logic [5:0] r, pr;
        logic       n, o, pn, po;
        logic [6:0] es, et, eu;
        bit         busy_ok;

        n_pass  = 0;
        n_total = 0;
        enc = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
        vecs[0] = '{6'd49,      1'b0, 1'b0, BL, S4, S9};
        vecs[1] = '{6'b111101,  1'b1, 1'b0, DA, BL, S3};
        vecs[2] = '{6'b100000,  1'b1, 1'b0, DA, S3, S2};
        vecs[3] = '{6'd63,      1'b0, 1'b0, BL, S6, S3};
        vecs[4] = '{6'd10,      1'b0, 1'b0, BL, S1, S0};
        vecs[5] = '{6'd9,       1'b0, 1'b0, BL, BL, S9};
        vecs[6] = '{6'd12,      1'b1, 1'b1, EE, RR, RR};
        vecs[7] = '{6'd5,       1'b0, 1'b0, BL, BL, S5};
        vecs[8] = '{6'd0,       1'b1, 1'b0, DA, BL, S0};

        // Reset state, then first conversion of result=0
        reset = 1'b0;
        drive(6'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_an", int'(bus.an), 3'b111);
        chk("reset_seg", int'(bus.seg), 7'h7F);
        reset = 1'b1;
        run_conv("zero", 1'b1);
        check_display("zero", BL, BL, S0);
        check_rotation();

        foreach (vecs[i]) begin
            drive(vecs[i].result, vecs[i].neg, vecs[i].ovf);
            run_conv($sformatf("vec%0d", i), 1'b0);
            check_display($sformatf("vec%0d", i), vecs[i].s, vecs[i].t, vecs[i].u);
        end

        pr = vecs[8].result; pn = vecs[8].neg; po = vecs[8].ovf;
        for (int i = 0; i < 24; i++) begin
            do begin
                r = 6'($urandom_range(0, 63));
                n = 1'($urandom_range(0, 1));
                o = ($urandom_range(0, 7) == 0);
            end while ({r, n, o} == {pr, pn, po} || {r, n, o} == {6'd5, 1'b0, 1'b0});
            pr = r; pn = n; po = o;
            drive(r, n, o);
            model(r, n, o, es, et, eu);
            run_conv($sformatf("rnd%0d", i), 1'b0);
            check_display($sformatf("rnd%0d", i), es, et, eu);
        end

        // Input change 5->2 seen at E3: latched 5, recapture at E8, '2' after E15
        drive(6'd5, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("midchg_busy_E0", int'(bus.busy), 1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        drive(6'd2, 1'b0, 1'b0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("midchg_busy_E6", int'(bus.busy), 1);
        @(posedge clk);
        @(negedge clk);
        chk("midchg_busy_drop_E7", int'(bus.busy), 0);
        @(posedge clk);
        @(negedge clk);
        chk("midchg_recapture_E8", int'(bus.busy), 1);
        busy_ok = 1'b1;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        chk("midchg_busy_E9_E14", int'(busy_ok), 1);
        @(posedge clk);
        @(negedge clk);
        chk("midchg_busy_drop_E15", int'(bus.busy), 0);
        check_display("midchg", BL, BL, S2);

        // Reset asserted just after E4 aborts, then a fresh conversion of 37
        drive(6'd37, 1'b0, 1'b0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_an", int'(bus.an), 3'b111);
        chk("abort_seg", int'(bus.seg), 7'h7F);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_conv("after_abort", 1'b1);
        check_display("after_abort", BL, S3, S7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
